sf_chan_sched: RTL and testbench
================================

Name: sf_chan_sched

Overview:
- Time-multiplexed smoothing-filter scheduler: NCH sample streams share one filter datapath through a round-robin arbiter.
- Per-channel filter state is held in a context register file, so each channel behaves as an independent first-order smoother: y += (x - y) >>> SHIFT.
- Sits between the multi-channel sample front end and downstream consumers.
- Output carries a channel tag and uses valid/ready backpressure.

Parameters:
- NCH, 4, number of input channels (2..16).
- DW, 16, signed sample/state width.
- SHIFT, 2, smoothing shift (1..DW-1); larger means heavier smoothing.
- CW, $clog2(NCH), channel index width (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  NCH  per-channel sample valid.
- in_data  in  NCH*DW  packed samples; channel i occupies bits [i*DW +: DW], signed.
- in_ready  out  NCH  per-channel accept; one-hot or zero.
- ch_clear  in  NCH  per-channel state clear, level-sampled each cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_ch  out  CW  channel of result.
- out_data  out  DW  smoothed result, signed.
- busy  out  1  high while S1 or output stage holds data.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_ch=0, out_data=0, busy=0, in_ready=0.
  - Also cleared: all state[i]=0, primed[i]=0, S1 valid=0, RR pointer=0.
- Pipeline, two stages:
  - S1 latches (x, ch).
  - Output stage: computes, writes state[ch], and registers out_*.
- Load enables:
  - out_load = !out_valid || out_ready.
  - s1_load = !s1_valid || out_load.
- Arbitration (combinational):
  - When s1_load=1, grant the first channel with in_valid=1, searching from rr_ptr upward with wrap NCH-1 -> 0.
  - in_ready = that one-hot grant; in_ready=0 when s1_load=0 or no valid.
  - Transfer occurs when in_valid[i] & in_ready[i]; then rr_ptr <= (granted+1) mod NCH.
  - rr_ptr is unchanged when there is no transfer.
- Latency and throughput:
  - Sample accepted at edge E0; its result has out_valid=1 after edge E1.
  - One result per cycle sustained while out_ready=1.
- Arithmetic, on S1 data at an out_load edge:
  - If primed[ch]=0: y_new = x.
  - Otherwise: diff = x - state[ch] in DW+1 signed; y_new = state[ch] + (diff >>> SHIFT) in DW+1, truncated to DW.
  - The result always lies between x and the old state, so no overflow or saturation logic is needed.
  - Rounding is toward -infinity.
  - state[ch] <= y_new; primed[ch] <= 1; out_data <= y_new; out_ch <= ch; out_valid <= 1.
- Back-to-back same channel: the state write and the next S1 compute are separated by one edge, so the second sample must use the updated state. No forwarding is required, but the bench checks it.
- Backpressure:
  - out_valid=1 with out_ready=0 holds out_ch and out_data stable; state is not written.
  - S1 holds; in_ready goes all zero once S1 is full.
- ch_clear[i]=1 at an edge: state[i] <= 0, primed[i] <= 0.
  - Clear coinciding with an output-stage update of channel i: clear wins for state and primed. The computed result is still emitted on out_data.
  - Clear does not affect a sample waiting in S1; that sample computes as unprimed if the clear has already landed.
- out_valid drops after an edge with out_ready=1 and no S1 data advancing.
- busy = s1_valid | out_valid.
- Reset mid-operation discards S1 and output-stage contents immediately; no partial output appears.

Test Plan:
- Priming, SHIFT=2:
  - ch0 sends 100 -> out_ch=0, out_data=100 one cycle after accept.
  - Then ch0 sends 200 -> out_data=125.
  - Then ch0 sends 200 -> out_data=143.
- Negative and rounding: ch1 primed at 0 (send 0), then send -3 -> out_data=-1; then send -32768 -> -8193.
- Round-robin: all four in_valid held high, out_ready=1 -> grants and out_ch sequence 0,1,2,3,0,1.
  - With only ch2 and ch3 valid -> 2,3,2,3.
  - One result per cycle, no gaps.
- Backpressure:
  - out_ready=0 for 3 cycles with all channels valid -> out_data/out_ch frozen.
  - Exactly one extra sample accepted (into S1), then in_ready=0.
  - On release, results resume in order with no loss or duplication.
- Clear collision:
  - ch0 primed at 400; assert ch_clear[0] on the same edge ch0's sample 800 computes -> out_data=500.
  - The next ch0 sample 60 -> out_data=60 (unprimed).
- Reset mid-stream: assert rst while out_valid=1 and S1 full -> out_valid, busy and in_ready go 0 immediately. After release, the first sample per channel passes through unchanged.

Source files
------------

// File: rtl/sf_chan_sched.sv
// Time-multiplexed first-order smoothing scheduler.
// NCH channels share one filter datapath through a round-robin arbiter. Each channel keeps
// its own state/primed context, so each behaves as an independent y += (x - y) >>> SHIFT.
// Pipeline: arbiter -> S1 (sample, channel) -> output stage (compute, state write, out_*).
module sf_chan_sched #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned DW    = 16,
    parameter int unsigned SHIFT = 2,
    parameter int unsigned CW    = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH*DW-1:0] in_data,
    output logic [NCH-1:0]    in_ready,
    input  logic [NCH-1:0]    ch_clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     out_ch,
    output logic [DW-1:0]     out_data,
    output logic              busy
);

    // Pipeline registers
    logic          s1_valid_q;
    logic [DW-1:0] s1_data_q;
    logic [CW-1:0] s1_ch_q;
    logic          out_valid_q;
    logic [CW-1:0] out_ch_q;
    logic [DW-1:0] out_data_q;
    logic [CW-1:0] rr_ptr_q, rr_ptr_d;

    // Per-channel context
    logic [DW-1:0]  state_q [NCH];
    logic [NCH-1:0] primed_q;

    // Handshake / arbitration signals
    logic           out_load;
    logic           s1_load;
    logic [NCH-1:0] grant;
    logic [CW-1:0]  grant_idx;
    logic           grant_found;
    logic           transfer;
    logic [DW-1:0]  in_word [NCH];

    // Datapath signals
    logic signed [DW:0] x_ext;
    logic signed [DW:0] st_ext;
    logic signed [DW:0] diff;
    logic signed [DW:0] sum;
    logic [DW-1:0]      y_new;
    logic               upd;
    logic               unused_sum_msb;

    assign out_load = !out_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || out_load;
    assign upd      = out_load && s1_valid_q;

    // Unpack the flat sample bus into per-channel words
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            in_word[i] = in_data[i*DW +: DW];
        end
    end

    // Round-robin search starting at rr_ptr_q, wrapping NCH-1 -> 0
    always_comb begin
        logic [CW:0]   pos;
        logic [CW-1:0] idx;
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        pos         = '0;
        idx         = '0;
        for (int k = 0; k < NCH; k++) begin
            pos = {1'b0, rr_ptr_q} + (CW+1)'(k);
            if (pos >= (CW+1)'(NCH)) begin
                pos = pos - (CW+1)'(NCH);
            end
            idx = pos[CW-1:0];
            if (!grant_found && in_valid[idx]) begin
                grant_found = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // Grant is only exposed while S1 can load; reset forces it low immediately
    assign in_ready = (s1_load && !rst) ? grant : '0;
    assign transfer = grant_found && s1_load && !rst;

    // Pointer advances past the granted channel only on an actual transfer
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (transfer) begin
            if (grant_idx == CW'(NCH - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + CW'(1);
            end
        end
    end

    // Filter step; result always lies between x and old state, so DW+1 bits never overflow
    always_comb begin
        x_ext  = {s1_data_q[DW-1], s1_data_q};
        st_ext = {state_q[s1_ch_q][DW-1], state_q[s1_ch_q]};
        diff   = x_ext - st_ext;
        sum    = st_ext + (diff >>> SHIFT);
        y_new  = primed_q[s1_ch_q] ? sum[DW-1:0] : s1_data_q;
    end

    assign unused_sum_msb = sum[DW];

    // S1 register and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_ch_q    <= '0;
            rr_ptr_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (s1_load) begin
                s1_valid_q <= transfer;
                if (transfer) begin
                    s1_data_q <= in_word[grant_idx];
                    s1_ch_q   <= grant_idx;
                end
            end
        end
    end

    // Output stage: holds stable while stalled, drops valid when nothing advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
        end else if (out_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_ch_q   <= s1_ch_q;
                out_data_q <= y_new;
            end
        end
    end

    // Channel context; a clear wins over a coincident update of the same channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= '0;
            end
            primed_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_clear[i]) begin
                    state_q[i]  <= '0;
                    primed_q[i] <= 1'b0;
                end else if (upd && (s1_ch_q == CW'(i))) begin
                    state_q[i]  <= y_new;
                    primed_q[i] <= 1'b1;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;
    assign busy      = s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_sf_chan_sched.sv
// Self-checking bench for sf_chan_sched: table-driven smoothing vectors, a scoreboard fed at
// input handshakes and drained at output handshakes, plus hand-written corner sequences.
module tb_sf_chan_sched;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int CW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    in_valid;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_ready;
    logic [NCH-1:0]    ch_clear;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_ch;
    logic [DW-1:0]     out_data;
    logic              busy;

    sf_chan_sched #(
        .NCH  (NCH),
        .DW   (DW),
        .SHIFT(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .ch_clear (ch_clear),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ch   (out_ch),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int x;
        int exp;
    } vec_t;

    typedef struct {
        int ch;
        int data;
    } exp_t;

    exp_t sb_q[$];
    int   m_st[NCH];
    bit   m_pr[NCH];
    int   checks   = 0;
    int   failures = 0;
    int   accepts  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_next(input int ch, input int x);
        int y;
        if (!m_pr[ch]) y = x;
        else           y = m_st[ch] + ((x - m_st[ch]) >>> 2);
        m_st[ch] = y;
        m_pr[ch] = 1'b1;
        return y;
    endfunction

    task automatic model_reset();
        sb_q.delete();
        for (int i = 0; i < NCH; i++) begin
            m_st[i] = 0;
            m_pr[i] = 1'b0;
        end
    endtask

    // Scoreboard: handshakes are decided by signals that are stable at the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_ch", int'(out_ch), e.ch);
                    chk("sb_data", int'($signed(out_data)), e.data);
                end
            end
            // A clear at this edge hits samples accepted at this edge or later
            for (int i = 0; i < NCH; i++) begin
                if (ch_clear[i]) begin
                    m_st[i] = 0;
                    m_pr[i] = 1'b0;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    exp_t e;
                    e.ch   = i;
                    e.data = model_next(i, int'($signed(in_data[i*DW +: DW])));
                    sb_q.push_back(e);
                    accepts++;
                end
            end
        end
    end

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = '0;
        ch_clear = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_data(input int ch, input int x);
        logic [31:0] xv;
        xv = x;
        in_data[ch*DW +: DW] = xv[DW-1:0];
    endtask

    task automatic send(input int ch, input int x);
        bit ok;
        ok = 1'b0;
        set_data(ch, x);
        in_valid[ch] = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (in_ready[ch]) ok = 1'b1;
        end
        @(posedge clk);
        #1 in_valid[ch] = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_out(output int n);
        bit ok;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 10) begin
            @(negedge clk);
            n++;
            if (out_valid) ok = 1'b1;
        end
        if (!ok) chk("out_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || sb_q.size() != 0) && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk("drain_sb_empty", sb_q.size(), 0);
        chk("drain_idle", int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   n;
        int   acc0;

        vecs[0] = '{0, 100, 100};
        vecs[1] = '{0, 200, 125};
        vecs[2] = '{0, 200, 143};
        vecs[3] = '{1, 0, 0};
        vecs[4] = '{1, -3, -1};
        vecs[5] = '{1, -32768, -8193};

        // Reset values, with every channel requesting
        rst       = 1'b1;
        in_valid  = '1;
        in_data   = '0;
        ch_clear  = '0;
        out_ready = 1'b1;
        model_reset();
        #3;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        in_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Round robin over all channels, one result per cycle
        for (int i = 0; i < NCH; i++) set_data(i, 10 * (i + 1));
        in_valid = '1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_all_grant", int'(in_ready), 1 << (k % 4));
            if (k >= 2) chk("rr_all_nogap", int'(out_valid), 1);
        end
        @(posedge clk);
        #1 in_valid = '0;
        drain();

        // Only ch2/ch3 requesting
        in_valid = 4'b1100;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_23_grant", int'(in_ready), (k % 2 == 0) ? 4 : 8);
            if (k >= 2) chk("rr_23_nogap", int'(out_valid), 1);
        end
        @(posedge clk);
        #1 in_valid = '0;
        drain();

        // Priming, negative values and rounding from a clean context
        do_reset();
        for (int v = 0; v < 6; v++) begin
            send(vecs[v].ch, vecs[v].x);
            wait_out(n);
            chk("tbl_latency", n, 2);
            chk("tbl_ch", int'(out_ch), vecs[v].ch);
            chk("tbl_data", int'($signed(out_data)), vecs[v].exp);
            @(posedge clk);
            #1;
        end
        drain();

        // Backpressure: one in output, one in S1, then everything stalls
        for (int i = 0; i < NCH; i++) set_data(i, 1000 * (i + 1));
        out_ready = 1'b0;
        in_valid  = '1;
        acc0      = accepts;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
            if (sb_q.size() > 0) begin
                chk("bp_hold_ch", int'(out_ch), sb_q[0].ch);
                chk("bp_hold_data", int'($signed(out_data)), sb_q[0].data);
            end else begin
                chk("bp_sb_nonempty", 0, 1);
            end
        end
        chk("bp_accepts", accepts - acc0, 2);
        chk("bp_sb_depth", sb_q.size(), 2);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 in_valid = '0;
        drain();

        // Clear colliding with the output-stage update of the same channel
        do_reset();
        send(0, 400);
        wait_out(n);
        chk("clr_prime", int'($signed(out_data)), 400);
        @(posedge clk);
        #1;
        set_data(0, 800);
        in_valid[0] = 1'b1;
        @(negedge clk);
        chk("clr_accept", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        ch_clear[0] = 1'b1;
        @(posedge clk);
        #1 ch_clear[0] = 1'b0;
        @(negedge clk);
        chk("clr_coll_valid", int'(out_valid), 1);
        chk("clr_coll_data", int'($signed(out_data)), 500);
        @(posedge clk);
        #1;
        send(0, 60);
        wait_out(n);
        chk("clr_unprimed", int'($signed(out_data)), 60);
        @(posedge clk);
        #1;
        drain();

        // Reset while output is stalled and S1 full
        for (int i = 0; i < NCH; i++) set_data(i, 7 * (i + 1));
        out_ready = 1'b0;
        in_valid  = '1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_busy_pre", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_out_valid", int'(out_valid), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_in_ready", int'(in_ready), 0);
        model_reset();
        in_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            send(i, -500 * (i + 1));
            wait_out(n);
            chk("post_rst_ch", int'(out_ch), i);
            chk("post_rst_data", int'($signed(out_data)), -500 * (i + 1));
            @(posedge clk);
            #1;
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
